// File: rtl/branch_unit_pkg.sv
// ============================================================================
// Module : branch_unit_pkg
// Desc   : Comparator op encodings and branch unit state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_unit_pkg;

  localparam int COM_OP_END = 2;

  localparam logic [COM_OP_END:0] COM_OP_EQ  = 3'd0;
  localparam logic [COM_OP_END:0] COM_OP_NE  = 3'd1;
  localparam logic [COM_OP_END:0] COM_OP_ONE = 3'd2;
  localparam logic [COM_OP_END:0] COM_OP_LT  = 3'd4;
  localparam logic [COM_OP_END:0] COM_OP_GE  = 3'd5;
  localparam logic [COM_OP_END:0] COM_OP_LTU = 3'd6;
  localparam logic [COM_OP_END:0] COM_OP_GEU = 3'd7;

  typedef enum logic [1:0] {
    BU_ST_IDLE = 2'd0,
    BU_ST_EXEC = 2'd1,
    BU_ST_RESP = 2'd2
  } bu_state_e;

endpackage

`default_nettype wire

// File: rtl/branch_unit_com.sv
// ============================================================================
// Module : branch_unit_com
// Desc   : Branch condition comparator; reserved encodings evaluate to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_unit_com
  import branch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [COM_OP_END:0] op,
  input  logic [XLEN-1:0]     lhs,
  input  logic [XLEN-1:0]     rhs,
  output logic                result
);

  always_comb begin
    result = 1'b0;
    case (op)
      COM_OP_EQ:  result = (lhs == rhs);
      COM_OP_NE:  result = (lhs != rhs);
      COM_OP_ONE: result = 1'b1;
      COM_OP_LT:  result = ($signed(lhs) <  $signed(rhs));
      COM_OP_GE:  result = ($signed(lhs) >= $signed(rhs));
      COM_OP_LTU: result = (lhs <  rhs);
      COM_OP_GEU: result = (lhs >= rhs);
      default:    result = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_unit.sv
// ============================================================================
// Module : branch_unit
// Desc   : Execute-stage branch sequencer: latch, compare, resolve target/link.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COM_OP_END:0] in_op,
  input  logic [XLEN-1:0]     in_lhs,
  input  logic [XLEN-1:0]     in_rhs,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                in_is_jalr,
  input  logic                in_pred_taken,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_taken,
  output logic [XLEN-1:0]     out_target,
  output logic [XLEN-1:0]     out_link,
  output logic                out_mispredict,
  output logic                out_misalign
);

  bu_state_e             state_q, state_d;
  logic [COM_OP_END:0]   op_q, op_d;
  logic [XLEN-1:0]       lhs_q, lhs_d, rhs_q, rhs_d, pc_q, pc_d, imm_q, imm_d;
  logic                  is_jalr_q, is_jalr_d, pred_q, pred_d;
  logic                  taken_q, taken_d, mispredict_q, mispredict_d, misalign_q, misalign_d;
  logic [XLEN-1:0]       target_q, target_d, link_q, link_d;

  logic                  com_result;
  logic                  in_fire;
  logic [XLEN-1:0]       target_sum, target_fix, link_sum;
  logic                  target_bad;

  branch_unit_com #(.XLEN(XLEN)) u_com (
    .op     (op_q),
    .lhs    (lhs_q),
    .rhs    (rhs_q),
    .result (com_result)
  );

  assign target_sum = (is_jalr_q ? lhs_q : pc_q) + imm_q;
  assign target_fix = is_jalr_q ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign link_sum   = pc_q + XLEN'(4);

  generate
    if (IALIGN == 16) begin : g_align16
      assign target_bad = target_fix[0];
    end else begin : g_align32
      assign target_bad = |target_fix[1:0];
    end
  endgenerate

  // RESP accepts the next request in the same cycle its result is consumed
  assign in_ready = !reset && !flush &&
                    ((state_q == BU_ST_IDLE) || ((state_q == BU_ST_RESP) && out_ready));
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lhs_d        = lhs_q;
    rhs_d        = rhs_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    is_jalr_d    = is_jalr_q;
    pred_d       = pred_q;
    taken_d      = taken_q;
    target_d     = target_q;
    link_d       = link_q;
    mispredict_d = mispredict_q;
    misalign_d   = misalign_q;

    if (flush) begin
      state_d      = BU_ST_IDLE;
      taken_d      = 1'b0;
      target_d     = '0;
      link_d       = '0;
      mispredict_d = 1'b0;
      misalign_d   = 1'b0;
    end else begin
      case (state_q)
        BU_ST_EXEC: begin
          taken_d      = com_result;
          target_d     = com_result ? target_fix : link_sum;
          link_d       = link_sum;
          mispredict_d = (com_result != pred_q);
          misalign_d   = com_result && target_bad;
          state_d      = BU_ST_RESP;
        end
        BU_ST_RESP: begin
          if (out_ready) state_d = in_valid ? BU_ST_EXEC : BU_ST_IDLE;
        end
        BU_ST_IDLE: begin
          if (in_valid) state_d = BU_ST_EXEC;
        end
        default: state_d = BU_ST_IDLE;
      endcase

      if (in_fire) begin
        op_d      = in_op;
        lhs_d     = in_lhs;
        rhs_d     = in_rhs;
        pc_d      = in_pc;
        imm_d     = in_imm;
        is_jalr_d = in_is_jalr;
        pred_d    = in_pred_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BU_ST_IDLE;
      op_q         <= '0;
      lhs_q        <= '0;
      rhs_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      is_jalr_q    <= 1'b0;
      pred_q       <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      mispredict_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lhs_q        <= lhs_d;
      rhs_q        <= rhs_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      is_jalr_q    <= is_jalr_d;
      pred_q       <= pred_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      link_q       <= link_d;
      mispredict_q <= mispredict_d;
      misalign_q   <= misalign_d;
    end
  end

  assign out_valid      = (state_q == BU_ST_RESP);
  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign out_link       = link_q;
  assign out_mispredict = mispredict_q;
  assign out_misalign   = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
// Module : tb_branch_unit
// Desc   : Directed vector table plus handshake/flush/reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_unit;
  import branch_unit_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] lhs, rhs, pc, imm;
    logic        jalr, pred;
    logic        e_taken;
    logic [31:0] e_target, e_link;
    logic        e_misp, e_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_lhs = '0, in_rhs = '0, in_pc = '0, in_imm = '0;
  logic        in_is_jalr = 1'b0, in_pred_taken = 1'b0;
  logic        out_valid, out_ready = 1'b0, out_taken, out_mispredict, out_misalign;
  logic [31:0] out_target, out_link;

  int tests = 0;
  int fails = 0;
  vec_t vecs[11];

  branch_unit #(.XLEN(32), .IALIGN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_pc(in_pc), .in_imm(in_imm),
    .in_is_jalr(in_is_jalr), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link),
    .out_mispredict(out_mispredict), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] lhs, input logic [31:0] rhs,
                              input logic [31:0] pc, input logic [31:0] imm, input logic jalr,
                              input logic pred, input logic t, input logic [31:0] tg,
                              input logic [31:0] lk, input logic mp, input logic ma);
    vec_t v;
    v.op = op; v.lhs = lhs; v.rhs = rhs; v.pc = pc; v.imm = imm; v.jalr = jalr; v.pred = pred;
    v.e_taken = t; v.e_target = tg; v.e_link = lk; v.e_misp = mp; v.e_mis = ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_op = v.op; in_lhs = v.lhs; in_rhs = v.rhs; in_pc = v.pc; in_imm = v.imm;
    in_is_jalr = v.jalr; in_pred_taken = v.pred;
  endtask

  task automatic chk_res(input string tag, input vec_t v);
    chk({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
    chk({tag, ".taken"},  {31'd0, out_taken}, {31'd0, v.e_taken});
    chk({tag, ".target"}, out_target, v.e_target);
    chk({tag, ".link"},   out_link, v.e_link);
    chk({tag, ".misp"},   {31'd0, out_mispredict}, {31'd0, v.e_misp});
    chk({tag, ".misal"},  {31'd0, out_misalign}, {31'd0, v.e_mis});
  endtask

  // Call at a negedge; returns at the negedge of the EXEC cycle.
  task automatic accept(input string tag, input vec_t v);
    int n = 0;
    drive(v);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".exec_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(COM_OP_EQ,  32'd5,        32'd5,        32'h100,      32'h20,       0, 0, 1, 32'h120,  32'h104, 1, 0);
    vecs[1]  = mk(COM_OP_LTU, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,       0, 0, 0, 32'h204,  32'h204, 0, 0);
    vecs[2]  = mk(COM_OP_LT,  32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,       0, 0, 1, 32'h240,  32'h204, 1, 0);
    vecs[3]  = mk(COM_OP_ONE, 32'h1003,     32'd0,        32'h300,      32'h0,        1, 1, 1, 32'h1002, 32'h304, 0, 1);
    vecs[4]  = mk(COM_OP_ONE, 32'h1003,     32'd0,        32'h300,      32'h1,        1, 1, 1, 32'h1004, 32'h304, 0, 0);
    vecs[5]  = mk(COM_OP_NE,  32'd1,        32'd2,        32'hFFFFFFFC, 32'h8,        0, 1, 1, 32'h4,    32'h0,   0, 0);
    vecs[6]  = mk(COM_OP_GE,  32'd3,        32'hFFFFFFFE, 32'h400,      32'h6,        0, 1, 1, 32'h406,  32'h404, 0, 1);
    vecs[7]  = mk(COM_OP_GEU, 32'd3,        32'hFFFFFFFE, 32'h400,      32'h6,        0, 1, 0, 32'h404,  32'h404, 1, 0);
    vecs[8]  = mk(3'd3,       32'd9,        32'd9,        32'h500,      32'h10,       0, 0, 0, 32'h504,  32'h504, 0, 0);
    vecs[9]  = mk(COM_OP_NE,  32'd7,        32'd7,        32'h510,      32'h10,       0, 0, 0, 32'h514,  32'h514, 0, 0);
    vecs[10] = mk(COM_OP_ONE, 32'd0,        32'd0,        32'h600,      32'hFFFFFF00, 0, 0, 1, 32'h500,  32'h604, 1, 0);

    // reset state
    @(posedge clk); @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.target", out_target, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      accept(tag, vecs[i]);
      @(negedge clk);
      chk_res(tag, vecs[i]);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
    end

    // backpressure then back-to-back accept
    accept("bp", vecs[0]);
    @(negedge clk);
    drive(vecs[2]);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_res($sformatf("bp.hold%0d", k), vecs[0]);
      chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.b2b_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp.b2b_exec", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk_res("bp.second", vecs[2]);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // flush in EXEC
    accept("fx", vecs[0]);
    flush = 1'b1;
    #1;
    chk("fx.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("fx.valid", {31'd0, out_valid}, 32'd0);
    chk("fx.taken", {31'd0, out_taken}, 32'd0);
    #1;
    chk("fx.idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("fx.no_result", {31'd0, out_valid}, 32'd0);

    // flush in RESP with out_ready and a new request offered
    accept("fr", vecs[5]);
    @(negedge clk);
    chk("fr.resp", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(vecs[1]);
    in_valid = 1'b1;
    #1;
    chk("fr.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("fr.valid", {31'd0, out_valid}, 32'd0);
    chk("fr.target", out_target, 32'd0);
    @(negedge clk);
    chk("fr.dropped", {31'd0, out_valid}, 32'd0);

    // reset in EXEC
    accept("rx", vecs[5]);
    reset = 1'b1;
    #1;
    chk("rx.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rx.valid", {31'd0, out_valid}, 32'd0);
    chk("rx.taken", {31'd0, out_taken}, 32'd0);
    chk("rx.target", out_target, 32'd0);
    chk("rx.link", out_link, 32'd0);
    chk("rx.flags", {30'd0, out_mispredict, out_misalign}, 32'd0);
    @(negedge clk);
    chk("rx.no_result", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
